// File: rtl/ysyx_25020037_muldiv.sv
// Iterative RV M-extension unit: radix-2 shift-add multiply and restoring divide
// sharing one 2*XLEN accumulator, with valid/ready on both sides and a flush abort.
module ysyx_25020037_muldiv #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      in_op,
  input  logic [XLEN-1:0] in_src1,
  input  logic [XLEN-1:0] in_src2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic            busy
);

  localparam logic [XLEN-1:0] ONES = '1;
  localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state, state_n;

  logic [CNT_W-1:0]  cnt;
  logic              is_mul, want_hi, is_rem, neg_res, fast;
  logic [XLEN-1:0]   dvs;
  logic [2*XLEN-1:0] acc;

  // Request decode: operand signedness, magnitudes and fast-path detection
  logic            s1_sgn_c, s2_sgn_c, neg1_c, neg2_c;
  logic [XLEN-1:0] abs1_c, abs2_c;
  logic            div0_c, ovf_c, mz_c, fast_c;
  logic [XLEN-1:0] fast_val_c;

  assign s1_sgn_c = (in_op == 3'd1) || (in_op == 3'd2) || (in_op == 3'd4) || (in_op == 3'd6);
  assign s2_sgn_c = (in_op == 3'd1) || (in_op == 3'd4) || (in_op == 3'd6);
  assign neg1_c   = s1_sgn_c & in_src1[XLEN-1];
  assign neg2_c   = s2_sgn_c & in_src2[XLEN-1];
  assign abs1_c   = neg1_c ? -in_src1 : in_src1;
  assign abs2_c   = neg2_c ? -in_src2 : in_src2;
  assign div0_c   = in_op[2] & (in_src2 == '0);
  assign ovf_c    = in_op[2] & ~in_op[0] & (in_src1 == SMIN) & (in_src2 == ONES);
  assign mz_c     = ~in_op[2] & ((in_src1 == '0) | (in_src2 == '0));
  assign fast_c   = div0_c | ovf_c | mz_c;

  always_comb begin
    fast_val_c = '0;
    if (div0_c)     fast_val_c = in_op[1] ? in_src1 : ONES;
    else if (ovf_c) fast_val_c = in_op[1] ? '0 : in_src1;
  end

  // One iteration step of each algorithm on the shared accumulator
  logic [XLEN:0]     mul_sum_c, rem_sh_c;
  logic [XLEN-1:0]   rem_sub_c, rem_new_c;
  logic              ge_c;
  logic [2*XLEN-1:0] mul_next_c, div_next_c;

  assign mul_sum_c  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, dvs} : '0);
  assign mul_next_c = {mul_sum_c, acc[XLEN-1:1]};
  assign rem_sh_c   = acc[2*XLEN-1:XLEN-1];
  assign ge_c       = rem_sh_c >= {1'b0, dvs};
  assign rem_sub_c  = rem_sh_c[XLEN-1:0] - dvs;
  assign rem_new_c  = ge_c ? rem_sub_c : rem_sh_c[XLEN-1:0];
  assign div_next_c = {rem_new_c, acc[XLEN-2:0], ge_c};

  // Final selection and the single sign fix-up
  logic [2*XLEN-1:0] prod_sel_c;
  logic [XLEN-1:0]   mul_res_c, div_raw_c, div_res_c, final_c;

  assign prod_sel_c = neg_res ? -acc : acc;
  assign mul_res_c  = want_hi ? prod_sel_c[2*XLEN-1:XLEN] : prod_sel_c[XLEN-1:0];
  assign div_raw_c  = is_rem ? acc[2*XLEN-1:XLEN] : acc[XLEN-1:0];
  assign div_res_c  = neg_res ? -div_raw_c : div_raw_c;
  assign final_c    = is_mul ? mul_res_c : div_res_c;

  assign in_ready = ~busy & ~flush;

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  if (in_valid) state_n = fast_c ? S_DONE : S_BUSY;
      S_BUSY:  if (cnt == CNT_W'(1)) state_n = S_DONE;
      S_DONE:  if (out_valid && out_ready) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
    if (flush) state_n = S_IDLE;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= S_IDLE;
      busy  <= 1'b0;
    end else begin
      state <= state_n;
      busy  <= (state_n != S_IDLE);
    end
  end

  // Datapath; out_valid rises one cycle after DONE is entered so the result settles first
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt        <= '0;
      is_mul     <= 1'b0;
      want_hi    <= 1'b0;
      is_rem     <= 1'b0;
      neg_res    <= 1'b0;
      fast       <= 1'b0;
      dvs        <= '0;
      acc        <= '0;
      out_valid  <= 1'b0;
      out_result <= '0;
    end else if (flush) begin
      cnt       <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            is_mul  <= ~in_op[2];
            want_hi <= |in_op[1:0];
            is_rem  <= in_op[1];
            neg_res <= (in_op[2] & in_op[1]) ? neg1_c : (neg1_c ^ neg2_c);
            fast    <= fast_c;
            dvs     <= in_op[2] ? abs2_c : abs1_c;
            acc     <= {{XLEN{1'b0}}, (in_op[2] ? abs1_c : abs2_c)};
            if (fast_c) begin
              out_result <= fast_val_c;
              cnt        <= '0;
            end else begin
              cnt <= CNT_W'(XLEN);
            end
          end
        end
        S_BUSY: begin
          acc <= is_mul ? mul_next_c : div_next_c;
          cnt <= cnt - CNT_W'(1);
        end
        S_DONE: begin
          if (!out_valid) begin
            out_valid <= 1'b1;
            if (!fast) out_result <= final_c;
          end else if (out_ready) begin
            out_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/ysyx_25020037_muldiv.md
Name: ysyx_25020037_muldiv

Overview:
Parametrised iterative RV M-extension unit: MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU on XLEN-bit operands.
Sits in EXU beside the single-cycle ALU; it is the multi-cycle successor that carries the ALU's arithmetic into multiply/divide.
Radix-2 shift-add multiplier and restoring divider share one datapath.
Valid/ready handshake on both sides; flush input for pipeline redirect.

Parameters:
XLEN, 32, operand/result width (≥8, power of 2)
CNT_W, $clog2(XLEN)+1, iteration counter width

Ports:
clock  input  1  system clock, all state on rising edge
reset  input  1  synchronous, active-high; clears all state
flush  input  1  abort current op, drop pending result
in_valid  input  1  request valid
in_ready  output  1  unit can accept (state IDLE and !flush)
in_op  input  3  funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
in_src1  input  XLEN  rs1 (multiplicand / dividend)
in_src2  input  XLEN  rs2 (multiplier / divisor)
out_valid  output  1  result valid, held until out_ready
out_ready  input  1  consumer accepts result
out_result  output  XLEN  result
busy  output  1  state != IDLE

Behaviour:
- Reset: state IDLE, out_valid 0, out_result 0, busy 0, in_ready 1, counter 0.
- States: IDLE -> (accept) BUSY or DONE; BUSY -> DONE when counter reaches 0; DONE -> IDLE on out_valid & out_ready.
- Accept = in_valid & in_ready. Op, operands and sign info are latched at the accept edge.
- Signed ops: latch absolute values and the result sign.
  - MULH: both operands signed. MULHSU: rs1 signed, rs2 unsigned.
  - DIV: quotient sign = s1^s2. REM: remainder sign = sign of dividend.
- Negation is applied once, when entering DONE.
- Multiply: 2*XLEN product register, one add/shift step per BUSY cycle, XLEN steps.
  - MUL returns product[XLEN-1:0]; MULH* return product[2XLEN-1:XLEN].
- Divide: restoring, one quotient bit per BUSY cycle, XLEN steps.
- Latency: accept at edge T -> out_valid high after edge T+XLEN+1 (BUSY for exactly XLEN cycles).
- Fast paths, out_valid after edge T+1 with no BUSY state:
  - divisor==0: DIV/DIVU -> all ones; REM/REMU -> src1.
  - Signed overflow (src1 = 1<<(XLEN-1), src2 = all ones): DIV -> src1; REM -> 0.
  - Multiply with either operand 0 -> 0.
- out_result and out_valid are stable while out_valid & !out_ready (backpressure); no new accept until the result drains.
- in_ready = (state==IDLE) & !flush. There is no same-cycle pass-through from DONE to a new accept; the next op is accepted one cycle after drain.
- flush (any state): next state IDLE, out_valid 0 next cycle, result discarded.
- flush has priority over accept and over out_ready in the same cycle.
- reset has priority over flush and over all other inputs. Reset mid-BUSY returns to IDLE with no output.
- All arithmetic is modulo 2^XLEN except the internal 2*XLEN product/remainder registers. No X propagation from unused operand bits.

Test Plan:
- MUL 7 × 0xFFFFFFF9 (-7), XLEN=32 -> 0xFFFFFFCF; out_valid exactly 33 cycles after accept; MULH of same -> 0xFFFFFFFF; MULHU -> 0x00000006.
- MULH 0x80000000 × 0x80000000 -> 0x40000000; MULHSU 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFF; MULHU -> 0xFFFFFFFE.
- DIV -7/2 -> 0xFFFFFFFD, REM -> 0xFFFFFFFF; DIVU 100/7 -> 14, REMU -> 2; each 33-cycle latency.
- DIV 5/0 -> 0xFFFFFFFF, REMU 5/0 -> 5, DIV 0x80000000/0xFFFFFFFF -> 0x80000000, REM -> 0; each out_valid 1 cycle after accept.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid -> result stable, in_ready 0, busy 1; release -> in_ready 1 next cycle.
- Flush at BUSY cycle 5, and separately reset at BUSY cycle 10 -> IDLE next cycle, no out_valid; a following DIVU 9/3 returns 3 correctly.
